// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: word storage behind a
// fixed-latency request/response handshake with error reporting.
//
// Handshake: the initiator asserts MemRead or MemWrite with addr/wdata and
// holds them until it sees ready (a one-cycle pulse in RESP). Requests are
// sampled only in IDLE, so a request still asserted when the FSM is back in
// IDLE starts a new access. err and rdata are only meaningful while ready=1.
module dmem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int DEPTH = 1 << ADDR_BITS;
  // BUSY lasts LATENCY-1 cycles; the counter runs 0..LATENCY-2.
  localparam logic [3:0] CNT_LAST = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   is_wr_q, is_wr_d;
  logic                   err_q, err_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   req_err;
  logic                   mem_we;
  logic [31:0]            mem [DEPTH];

  always_comb begin
    req_err = (MemRead & MemWrite)
            | (addr[1:0] != 2'b00)
            | (addr[31:ADDR_BITS+2] != '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (MemRead | MemWrite) begin
          idx_d   = addr[ADDR_BITS+1:2];
          wdata_d = wdata;
          is_wr_d = MemWrite;
          err_d   = req_err;
          cnt_d   = 4'd0;
          state_d = (LATENCY > 1) ? S_BUSY : S_RESP;
        end
      end
      S_BUSY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        mem_we  = is_wr_q & ~err_q;
      end
      default: state_d = S_IDLE;
    endcase

    // Load read data on the edge entering RESP so it is stable all of RESP.
    if ((state_d == S_RESP) && (state_q != S_RESP) && !is_wr_d && !err_d) begin
      rdata_d = mem[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      is_wr_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is never cleared; a reset edge suppresses the pending commit.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign ready     = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign err       = ready & err_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2 and one at
// LATENCY=1, sharing a driver, an expected-response queue and a monitor.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rd, wr;
  logic [31:0] a, d;
  bit          sel;

  logic        rd_2, wr_2, rdy_2, bsy_2, er_2;
  logic        rd_1, wr_1, rdy_1, bsy_1, er_1;
  logic [31:0] rdat_2, rdat_1;
  logic [1:0]  st_2, st_1;
  logic        rdy, bsy, er;
  logic [31:0] rdat;

  assign rd_2 = sel ? 1'b0 : rd;
  assign wr_2 = sel ? 1'b0 : wr;
  assign rd_1 = sel ? rd : 1'b0;
  assign wr_1 = sel ? wr : 1'b0;
  assign rdy  = sel ? rdy_1 : rdy_2;
  assign bsy  = sel ? bsy_1 : bsy_2;
  assign er   = sel ? er_1 : er_2;
  assign rdat = sel ? rdat_1 : rdat_2;

  dmem_responder #(.ADDR_BITS(8), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(rst_n), .MemRead(rd_2), .MemWrite(wr_2),
    .addr(a), .wdata(d), .rdata(rdat_2), .ready(rdy_2), .busy(bsy_2),
    .err(er_2), .dbg_state(st_2)
  );

  dmem_responder #(.ADDR_BITS(8), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(rst_n), .MemRead(rd_1), .MemWrite(wr_1),
    .addr(a), .wdata(d), .rdata(rdat_1), .ready(rdy_1), .busy(bsy_1),
    .err(er_1), .dbg_state(st_1)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;
  bit          prev_chain = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse consumes one expected {err, rdata}.
  always @(negedge clk) begin
    if (rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_ready: got err=%b rdata=%h expected no response", er, rdat);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_err_rdata", {31'd0, er, rdat}, {31'd0, mon_e});
      end
    end
  end

  // Called at a negedge with the DUT in IDLE, or in RESP when the previous
  // call chained. Returns at the RESP negedge (chain_next) or the next IDLE one.
  task automatic xact(input string name, input bit r, input bit w,
                      input logic [31:0] ad, input logic [31:0] dt,
                      input bit e_err, input logic [31:0] e_rd, input bit chain_next);
    int n;
    int exp_n;
    bit first_chain;
    first_chain = prev_chain;
    exp_n = (sel ? 1 : 2) + (first_chain ? 1 : 0);
    rd = r; wr = w; a = ad; d = dt;
    exp_q.push_back({e_err, e_rd});
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (rdy !== 1'b1 && !first_chain) check({name, "_busy_wait"}, {63'd0, bsy}, 64'd1);
    end while (rdy !== 1'b1 && n < 40);
    check({name, "_latency"}, 64'(n), 64'(exp_n));
    check({name, "_busy_resp"}, {63'd0, bsy}, 64'd1);
    prev_chain = chain_next;
    if (!chain_next) begin
      rd = 1'b0; wr = 1'b0;
      @(negedge clk);
      check({name, "_idle_after"}, {62'd0, rdy, bsy}, 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; a = 32'd0; d = 32'd0; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {29'd0, rdy, bsy, er, rdat}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", {29'd0, rdy, bsy, er, rdat}, 64'd0);

    // LATENCY=2 instance
    xact("w10",      0, 1, 32'h10,  32'hDEADBEEF, 0, 32'h00000000, 0);
    xact("r10",      1, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 0);
    xact("r12_mis",  1, 0, 32'h12,  32'h0,        1, 32'hDEADBEEF, 0);
    xact("w21_mis",  0, 1, 32'h21,  32'h77777777, 1, 32'hDEADBEEF, 0);
    xact("w20",      0, 1, 32'h20,  32'hCAFEF00D, 0, 32'hDEADBEEF, 0);
    xact("rw20",     1, 1, 32'h20,  32'h11111111, 1, 32'hDEADBEEF, 0);
    xact("r20",      1, 0, 32'h20,  32'h0,        0, 32'hCAFEF00D, 0);
    xact("w00",      0, 1, 32'h0,   32'h0A0A0A0A, 0, 32'hCAFEF00D, 0);
    xact("w400_oor", 0, 1, 32'h400, 32'hBAD0BAD0, 1, 32'hCAFEF00D, 0);
    xact("r00",      1, 0, 32'h0,   32'h0,        0, 32'h0A0A0A0A, 0);
    xact("w3fc",     0, 1, 32'h3FC, 32'h55AA55AA, 0, 32'h0A0A0A0A, 0);
    xact("r3fc",     1, 0, 32'h3FC, 32'h0,        0, 32'h55AA55AA, 0);
    xact("r10_again",1, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 0);

    // Abort a write with reset during BUSY
    rd = 1'b0; wr = 1'b1; a = 32'h20; d = 32'h12345678;
    @(negedge clk);
    check("abort_busy", {63'd0, bsy}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_outputs", {29'd0, rdy, bsy, er, rdat}, 64'd0);
    rst_n = 1'b1; wr = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_ready", {63'd0, rdy}, 64'd0);
    end
    xact("r20_after_abort", 1, 0, 32'h20, 32'h0, 0, 32'hCAFEF00D, 0);

    // LATENCY=1 instance, back-to-back with request held until ready
    sel = 1'b1;
    @(negedge clk);
    xact("l1_w0", 0, 1, 32'h0, 32'd1, 0, 32'd0, 1);
    xact("l1_w4", 0, 1, 32'h4, 32'd2, 0, 32'd0, 1);
    xact("l1_w8", 0, 1, 32'h8, 32'd3, 0, 32'd0, 0);
    xact("l1_r0", 1, 0, 32'h0, 32'h0, 0, 32'd1, 1);
    xact("l1_r4", 1, 0, 32'h4, 32'h0, 0, 32'd2, 1);
    xact("l1_r8", 1, 0, 32'h8, 32'h0, 0, 32'd3, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
